// File: rtl/xy_tag_alloc_if.sv
// Request/result bundle between the flush requester, the tag allocator and the PE array.
// Latency: none, wires only.
// Backpressure: none; flush is a level request and flush_busy tells the requester when it is ignored.
interface xy_tag_alloc_if #(
  parameter int NUM_COL = 10,
  parameter int NUM_ROW = 2,
  parameter int KS_W    = 8,
  parameter int TAG_W   = $clog2(NUM_COL) + 1,
  parameter int YTAG_W  = $clog2(NUM_ROW) + 1
);
  // Request side
  logic                      flush;
  logic [KS_W-1:0]           kernel_size;
  logic [TAG_W-1:0]          tag_offset;
  // Result side
  logic [NUM_COL*TAG_W-1:0]  tag_out;
  logic [NUM_COL-1:0]        tag_locks;
  logic [NUM_ROW*YTAG_W-1:0] y_tag_out;
  logic [NUM_ROW-1:0]        y_tag_locks;
  logic [TAG_W-1:0]          num_groups;
  logic                      flush_busy;
  logic                      alloc_done;
  logic                      cfg_err;

  modport master (
    output flush, kernel_size, tag_offset,
    input  tag_out, tag_locks, y_tag_out, y_tag_locks, num_groups,
           flush_busy, alloc_done, cfg_err
  );

  modport slave (
    input  flush, kernel_size, tag_offset,
    output tag_out, tag_locks, y_tag_out, y_tag_locks, num_groups,
           flush_busy, alloc_done, cfg_err
  );
endinterface

// File: rtl/xy_tag_alloc.sv
// Column/row tag allocator: on flush, programs kernel-group tags per PE column and row tags per PE row.
// Latency: NUM_COL+NUM_ROW+2 busy cycles per allocation (2 when the config is illegal); alloc_done in the last one.
// Backpressure: flush is sampled only in IDLE; requests while busy are dropped. Optional macro: TAG_OFFSET_EN (tag rotation).
module xy_tag_alloc #(
  parameter int NUM_COL = 10,
  parameter int NUM_ROW = 2,
  parameter int KS_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  xy_tag_alloc_if.slave  bus
);
  localparam int TAG_W  = $clog2(NUM_COL) + 1;
  localparam int YTAG_W = $clog2(NUM_ROW) + 1;
  localparam int CI_W   = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  localparam int RI_W   = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
  localparam logic [TAG_W-1:0]  TAG_INV  = {TAG_W{1'b1}};
  localparam logic [YTAG_W-1:0] YTAG_INV = {YTAG_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR      = 3'd1,
    COL_WALK = 3'd2,
    ROW_WALK = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Captured request and walk bookkeeping
  logic [KS_W-1:0]   ks_q;
  logic [CI_W-1:0]   col_cnt;
  logic [RI_W-1:0]   row_cnt;
  logic [TAG_W-1:0]  pos;
  logic              grp_vld;

  // Result registers
  logic [TAG_W-1:0]  tag_q   [NUM_COL];
  logic [YTAG_W-1:0] y_tag_q [NUM_ROW];
  logic [NUM_COL-1:0] lock_q;
  logic [NUM_ROW-1:0] y_lock_q;
  logic [TAG_W-1:0]  groups_q;
  logic              cfg_err_q;

  // Decoded per-cycle controls
  logic [31:0]       ks32;
  logic              cfg_bad;
  logic              col_vld;
  logic              pos_wrap;
  logic              col_last;
  logic              row_last;
  logic              row_vld;
  logic [TAG_W-1:0]  col_tag;
  logic              busy;
  logic              done;

  assign ks32     = 32'(ks_q);
  assign pos_wrap = (32'(pos) == ks32 - 32'd1);
  assign col_last = (32'(col_cnt) == NUM_COL - 1);
  assign row_last = (32'(row_cnt) == NUM_ROW - 1);
  assign row_vld  = (32'(row_cnt) < ks32);

`ifdef TAG_OFFSET_EN
  // Rotated tag counter: starts at the captured offset and wraps at ks-1.
  logic [TAG_W-1:0] off_q;
  logic [TAG_W-1:0] tag_cnt;
  logic             tag_wrap;

  assign tag_wrap = (32'(tag_cnt) == ks32 - 32'd1);
  assign cfg_bad  = (ks_q == '0) || (ks32 > NUM_COL) || (32'(off_q) >= ks32);
  assign col_tag  = tag_cnt;

  // Offset capture and rotated tag counter
  always_ff @(posedge clk) begin
    if (rst) begin
      off_q   <= '0;
      tag_cnt <= '0;
    end else begin
      if (state == IDLE && bus.flush) off_q <= bus.tag_offset;
      if (state == CLR) tag_cnt <= off_q;
      else if (state == COL_WALK) tag_cnt <= tag_wrap ? '0 : tag_cnt + 1'b1;
    end
  end
`else
  // Without rotation the tag is simply the position inside the group.
  logic unused_tag_offset;
  assign unused_tag_offset = ^bus.tag_offset;
  assign cfg_bad = (ks_q == '0) || (ks32 > NUM_COL);
  assign col_tag = pos;
`endif

  // A group is judged once, at its first column; later columns inherit the verdict.
  assign col_vld = (pos == '0) ? ((32'(col_cnt) + ks32) <= NUM_COL) : grp_vld;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.flush) state_nxt = CLR;
      end
      CLR:      state_nxt = cfg_bad ? DONE : COL_WALK;
      COL_WALK: if (col_last) state_nxt = ROW_WALK;
      ROW_WALK: if (row_last) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture, clear and per-column / per-row programming
  always_ff @(posedge clk) begin
    if (rst) begin
      ks_q      <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      pos       <= '0;
      grp_vld   <= 1'b0;
      lock_q    <= '0;
      y_lock_q  <= '0;
      groups_q  <= '0;
      cfg_err_q <= 1'b0;
      for (int c = 0; c < NUM_COL; c++) tag_q[c]   <= TAG_INV;
      for (int r = 0; r < NUM_ROW; r++) y_tag_q[r] <= YTAG_INV;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush) ks_q <= bus.kernel_size;
        end
        CLR: begin
          col_cnt   <= '0;
          row_cnt   <= '0;
          pos       <= '0;
          grp_vld   <= 1'b0;
          lock_q    <= '0;
          y_lock_q  <= '0;
          groups_q  <= '0;
          cfg_err_q <= cfg_bad;
          for (int c = 0; c < NUM_COL; c++) tag_q[c]   <= TAG_INV;
          for (int r = 0; r < NUM_ROW; r++) y_tag_q[r] <= YTAG_INV;
        end
        COL_WALK: begin
          tag_q[col_cnt]  <= col_vld ? col_tag : TAG_INV;
          lock_q[col_cnt] <= col_vld;
          if (pos == '0 && col_vld) groups_q <= groups_q + 1'b1;
          grp_vld <= col_vld;
          pos     <= pos_wrap ? '0 : pos + 1'b1;
          col_cnt <= col_cnt + 1'b1;
        end
        ROW_WALK: begin
          y_tag_q[row_cnt]  <= row_vld ? YTAG_W'(row_cnt) : YTAG_INV;
          y_lock_q[row_cnt] <= row_vld;
          row_cnt <= row_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Flatten tag arrays onto the bus
  always_comb begin
    bus.tag_out   = '0;
    bus.y_tag_out = '0;
    for (int c = 0; c < NUM_COL; c++) bus.tag_out[c*TAG_W +: TAG_W]     = tag_q[c];
    for (int r = 0; r < NUM_ROW; r++) bus.y_tag_out[r*YTAG_W +: YTAG_W] = y_tag_q[r];
  end

  assign bus.tag_locks   = lock_q;
  assign bus.y_tag_locks = y_lock_q;
  assign bus.num_groups  = groups_q;
  assign bus.flush_busy  = busy;
  assign bus.alloc_done  = done;
  assign bus.cfg_err     = cfg_err_q;

endmodule
